// File: rtl/nibble_sequencer_if.sv
// Run-control and fetch bus between the nibble sequencer and its controller.
// Groups debug handshake, decoder strobes and fetch/flag outputs.
interface nibble_sequencer_if #(
  parameter int ADDR_W = 12
);
  logic              run_en;
  logic              step_req;
  logic [7:0]        prog_byte;
  logic              inc_pc;
  logic              load_pc;
  logic              load_flags;
  logic [ADDR_W-1:0] load_addr;
  logic              alu_c;
  logic              alu_z;
  logic [ADDR_W-1:0] pc;
  logic              phase;
  logic [3:0]        instr;
  logic [3:0]        oprnd;
  logic              c_flag;
  logic              z_flag;
  logic              running;
  logic              step_ack;

  modport master (
    output run_en, step_req, prog_byte,
    output inc_pc, load_pc, load_flags,
    output load_addr, alu_c, alu_z,
    input  pc, phase, instr, oprnd,
    input  c_flag, z_flag, running, step_ack
  );

  modport slave (
    input  run_en, step_req, prog_byte,
    input  inc_pc, load_pc, load_flags,
    input  load_addr, alu_c, alu_z,
    output pc, phase, instr, oprnd,
    output c_flag, z_flag, running, step_ack
  );
endinterface

// File: rtl/nibble_sequencer.sv
// Nibble CPU sequencer: PC, fetch/execute phase, fetch register, C/Z flags,
// plus halt / run / single-step control with a step acknowledge pulse.
module nibble_sequencer #(
  parameter int              ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          reset,
  nibble_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STEP
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              phase_q, phase_d;
  logic [7:0]        fetch_q, fetch_d;
  logic              c_q, c_d;
  logic              z_q, z_d;
  logic              ack_q, ack_d;
  logic              armed_q, armed_d;
  logic              active;

  assign active = (state_q != IDLE);

  always_comb begin
    pc_d    = pc_q;
    phase_d = phase_q;
    fetch_d = fetch_q;
    c_d     = c_q;
    z_d     = z_q;
    if (active) begin
      phase_d = ~phase_q;
      if (!phase_q) begin
        fetch_d = bus.prog_byte;
      end else if (bus.load_flags) begin
        c_d = bus.alu_c;
        z_d = bus.alu_z;
      end
      if (bus.load_pc) begin
        pc_d = bus.load_addr;
      end else if (bus.inc_pc) begin
        pc_d = pc_q + ADDR_W'(1);
      end
    end
  end

  // Halts only leave from an execute cycle, so IDLE always sits at phase 0.
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    armed_d = armed_q | ~bus.step_req;
    unique case (state_q)
      IDLE: begin
        if (bus.run_en) begin
          state_d = RUN;
        end else if (bus.step_req && armed_q) begin
          state_d = STEP;
          armed_d = 1'b0;
        end
      end
      RUN: begin
        if (phase_q && !bus.run_en) state_d = IDLE;
      end
      STEP: begin
        if (phase_q) begin
          state_d = IDLE;
          ack_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      phase_q <= 1'b0;
      fetch_q <= 8'h00;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      ack_q   <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      phase_q <= phase_d;
      fetch_q <= fetch_d;
      c_q     <= c_d;
      z_q     <= z_d;
      ack_q   <= ack_d;
      armed_q <= armed_d;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.phase    = phase_q;
  assign bus.instr    = fetch_q[7:4];
  assign bus.oprnd    = fetch_q[3:0];
  assign bus.c_flag   = c_q;
  assign bus.z_flag   = z_q;
  assign bus.running  = active;
  assign bus.step_ack = ack_q;

endmodule

// File: tb/tb_nibble_sequencer.sv
// Bench for nibble_sequencer: directed scenarios plus random stimulus,
// every cycle compared against a cycle-count based reference model.
module tb_nibble_sequencer;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nibble_sequencer_if #(.ADDR_W(AW)) bus ();

  nibble_sequencer #(
    .ADDR_W  (AW),
    .RESET_PC('0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  int m_pc;
  bit m_phase;
  int m_byte;
  bit m_c, m_z;
  bit m_run;
  int m_step_left;
  bit m_armed;
  bit m_ack;
  int acks;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_step();
    bit act;
    bit ack_n;
    if (!reset) begin
      m_pc = 0; m_phase = 0; m_byte = 0;
      m_c = 0; m_z = 0; m_run = 0;
      m_step_left = 0; m_armed = 1; m_ack = 0;
      return;
    end
    act = m_run || (m_step_left > 0);
    ack_n = 0;
    if (act) begin
      if (!m_phase) m_byte = int'(bus.prog_byte);
      else if (bus.load_flags) begin
        m_c = bus.alu_c;
        m_z = bus.alu_z;
      end
      if (bus.load_pc) m_pc = int'(bus.load_addr);
      else if (bus.inc_pc) m_pc = (m_pc + 1) % (1 << AW);
    end
    if (m_step_left > 0) begin
      m_step_left--;
      if (m_step_left == 0) ack_n = 1;
    end else if (m_run) begin
      if (m_phase && !bus.run_en) m_run = 0;
    end else if (bus.run_en) begin
      m_run = 1;
    end else if (bus.step_req && m_armed) begin
      m_step_left = 2;
      m_armed = 0;
    end
    if (!bus.step_req) m_armed = 1;
    if (act) m_phase = !m_phase;
    m_ack = ack_n;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("pc", 32'(bus.pc), 32'(m_pc));
    chk("phase", 32'(bus.phase), 32'(m_phase));
    chk("instr", 32'(bus.instr), 32'(m_byte >> 4));
    chk("oprnd", 32'(bus.oprnd), 32'(m_byte & 15));
    chk("c_flag", 32'(bus.c_flag), 32'(m_c));
    chk("z_flag", 32'(bus.z_flag), 32'(m_z));
    chk("running", 32'(bus.running),
        32'(m_run || m_step_left > 0));
    chk("step_ack", 32'(bus.step_ack), 32'(m_ack));
    if (bus.step_ack === 1'b1) acks++;
  endtask

  task automatic strobes_off();
    bus.inc_pc = 0;
    bus.load_pc = 0;
    bus.load_flags = 0;
    bus.alu_c = 0;
    bus.alu_z = 0;
  endtask

  initial begin
    int run_p;
    int base;
    reset = 0;
    bus.run_en = 0;
    bus.step_req = 0;
    bus.prog_byte = 8'h4A;
    bus.load_addr = '0;
    strobes_off();
    tick();
    tick();
    chk("rst_pc", 32'(bus.pc), 0);
    chk("rst_running", 32'(bus.running), 0);
    reset = 1;

    // run, incrementing only on fetch cycles
    bus.run_en = 1;
    tick();
    bus.inc_pc = 1;
    tick();
    chk("t1_instr", 32'(bus.instr), 4);
    chk("t1_oprnd", 32'(bus.oprnd), 32'hA);
    chk("t1_pc", 32'(bus.pc), 1);
    chk("t1_phase", 32'(bus.phase), 1);
    for (int i = 0; i < 4; i++) begin
      bus.inc_pc = !m_phase;
      bus.prog_byte = 8'h5B + 8'(i);
      tick();
    end

    // load beats inc, then all-ones wraps
    bus.inc_pc = 1;
    bus.load_pc = 1;
    bus.load_addr = 12'h123;
    if (!m_phase) tick();
    tick();
    chk("t2_load", 32'(bus.pc), 32'h123);
    bus.inc_pc = 0;
    bus.load_addr = 12'hFFF;
    tick();
    bus.load_pc = 0;
    bus.inc_pc = 1;
    tick();
    chk("t2_wrap", 32'(bus.pc), 0);
    bus.inc_pc = 0;

    // flags on execute only
    if (m_phase) tick();
    bus.load_flags = 1;
    bus.alu_c = 1;
    tick();
    chk("t3_c_fetch", 32'(bus.c_flag), 0);
    tick();
    chk("t3_c_exec", 32'(bus.c_flag), 1);
    chk("t3_z_exec", 32'(bus.z_flag), 0);
    strobes_off();

    // drop run_en on a fetch cycle
    bus.run_en = 0;
    bus.inc_pc = 1;
    tick();
    chk("t4_still_run", 32'(bus.running), 1);
    tick();
    chk("t4_idle", 32'(bus.running), 0);
    chk("t4_phase", 32'(bus.phase), 0);
    base = m_pc;
    for (int i = 0; i < 10; i++) tick();
    chk("t4_frozen", 32'(bus.pc), 32'(base));

    // held step_req gives one step; re-arm gives a second
    acks = 0;
    bus.step_req = 1;
    for (int i = 0; i < 8; i++) tick();
    chk("t5_one_ack", 32'(acks), 1);
    chk("t5_pc", 32'(bus.pc), 32'(base + 2));
    bus.step_req = 0;
    tick();
    bus.step_req = 1;
    for (int i = 0; i < 6; i++) tick();
    chk("t5_two_ack", 32'(acks), 2);
    bus.step_req = 0;
    strobes_off();

    // reset mid-instruction at execute
    bus.run_en = 1;
    tick();
    bus.load_pc = 1;
    bus.load_addr = 12'h045;
    bus.load_flags = 1;
    bus.alu_z = 1;
    if (m_phase) tick();
    tick();
    chk("t6_pc_pre", 32'(bus.pc), 32'h045);
    reset = 0;
    tick();
    chk("t6_pc", 32'(bus.pc), 0);
    chk("t6_phase", 32'(bus.phase), 0);
    chk("t6_running", 32'(bus.running), 0);
    reset = 1;
    bus.run_en = 0;
    strobes_off();
    tick();

    // random segments with varying run/step bias
    for (int seg = 0; seg < 15; seg++) begin
      run_p = int'($urandom_range(0, 100));
      for (int i = 0; i < 200; i++) begin
        reset = ($urandom_range(0, 199) != 0);
        bus.run_en = ($urandom_range(0, 99) < run_p);
        if ($urandom_range(0, 4) == 0) bus.step_req = ~bus.step_req;
        bus.prog_byte = 8'($urandom);
        bus.inc_pc = 1'($urandom);
        bus.load_pc = ($urandom_range(0, 3) == 0);
        bus.load_flags = 1'($urandom);
        bus.load_addr = 12'($urandom);
        if ($urandom_range(0, 9) == 0) bus.load_addr = 12'hFFF;
        bus.alu_c = 1'($urandom);
        bus.alu_z = 1'($urandom);
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
